// File: rtl/ysyx_25020047_pkg.sv
// ysyx_25020047_pkg
// Shared definitions for the ysyx_25020047 memory responder:
//   - RESP_OKAY / RESP_SLVERR response codes
//   - state_t, the responder FSM state encoding (exported on dbg_state)
//   - LFSR_SEED / LFSR_TAPS and lfsr_next() for the random wait-state source
package ysyx_25020047_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        RD_RESP = 3'd2,
        WR_WAIT = 3'd3,
        WR_RESP = 3'd4
    } state_t;

    // x^8 + x^6 + x^5 + x^4 + 1, Fibonacci form shifting left:
    // feedback is the XOR of bits 7, 5, 4 and 3.
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        return {q[6:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/ysyx_25020047_lfsr8.sv
// ysyx_25020047_lfsr8
// Free-running 8-bit maximal-length LFSR used as the random wait-state
// source. Reloads LFSR_SEED on reset and advances on every clock.
// Ports:
//   clk  in   clock, rising edge
//   rst  in   asynchronous active-low reset
//   out  out  current LFSR value [7:0]
module ysyx_25020047_lfsr8
    import ysyx_25020047_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] out
);

    logic [7:0] q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= LFSR_SEED;
        end else begin
            q <= lfsr_next(q);
        end
    end

    assign out = q;

endmodule

// File: rtl/ysyx_25020047_sram.sv
// ysyx_25020047_sram
// Slave-side memory responder for one NPC initiator (IFU or LSU). Holds a
// word-addressed array of DEPTH 32-bit words mapped at BASE and answers one
// transaction at a time after a wait of D cycles.
//
// Optional feature macro: YSYX_25020047_SRAM_RAND_DELAY_EN
//   defined   : D = 1 + lfsr[3:0] (1..16), sampled at the accepting edge
//   undefined : D = LATENCY for every transaction, no LFSR
//
// Parameters: BASE (first mapped byte), DEPTH (words, power of two),
//             LATENCY (fixed wait, >= 1)
// Ports:
//   clk, rst                  clock and asynchronous active-low reset
//   araddr/arvalid/arready    read address channel
//   rdata/rresp/rvalid/rready read data channel
//   awaddr/awvalid/awready    write address channel
//   wdata/wstrb/wvalid/wready write data channel (byte mask in wstrb)
//   bresp/bvalid/bready       write response channel
//   dbg_state                 current FSM state
//
// Handshake rule for every channel: a transfer happens on a rising edge where
// valid and ready are both high. A source never drops valid or changes its
// payload until that edge; arready/awready/wready depend only on the state
// and the request valids, never on rready/bready.
module ysyx_25020047_sram
    import ysyx_25020047_pkg::*;
#(
    parameter logic [31:0] BASE    = 32'h8000_0000,
    parameter int          DEPTH   = 4096,
    parameter int          LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    output state_t      dbg_state
);

    localparam int          IDX_W = $clog2(DEPTH);
    localparam int          LAT_W = $clog2(LATENCY + 1);
    // Wide enough for LATENCY and for the 1..16 random range.
    localparam int          CNT_W = (LAT_W > 5) ? LAT_W : 5;
    localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;

    logic [31:0]      mem [DEPTH];

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] delay;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [3:0]       wstrb_q;

    logic             wr_acc;
    logic             rd_acc;
    logic             waiting;
    logic             expire;
    logic [31:0]      offset;
    logic             in_range;
    logic [IDX_W-1:0] idx;

    // ---------------------------------------------------------------
    // Wait-state source
    // ---------------------------------------------------------------
`ifdef YSYX_25020047_SRAM_RAND_DELAY_EN
    logic [7:0] lfsr;

    ysyx_25020047_lfsr8 u_lfsr (
        .clk (clk),
        .rst (rst),
        .out (lfsr)
    );

    assign delay = CNT_W'({1'b0, lfsr[3:0]} + 5'd1);
`else
    assign delay = CNT_W'(LATENCY);
`endif

    // ---------------------------------------------------------------
    // Request acceptance: a write with both AW and W present wins over a
    // read; AW and W are only ever taken together.
    // ---------------------------------------------------------------
    assign wr_acc  = (state == IDLE) && awvalid && wvalid;
    assign rd_acc  = (state == IDLE) && arvalid && !(awvalid && wvalid);
    assign arready = (state == IDLE) && !(awvalid && wvalid);
    assign awready = wr_acc;
    assign wready  = wr_acc;

    assign rvalid    = (state == RD_RESP);
    assign bvalid    = (state == WR_RESP);
    assign dbg_state = state;

    // ---------------------------------------------------------------
    // Address decode on the latched address. The subtraction wraps for
    // addresses below BASE, so the lower bound is checked separately.
    // ---------------------------------------------------------------
    assign offset   = addr_q - BASE;
    assign in_range = (addr_q >= BASE) && ({1'b0, offset} < SPAN);
    assign idx      = addr_q[IDX_W+1:2];

    assign waiting  = (state == RD_WAIT) || (state == WR_WAIT);
    // The counter is loaded with D at acceptance; the edge that sees 1
    // is the D-th edge after acceptance and raises the response.
    assign expire   = (cnt <= CNT_W'(1));

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (wr_acc) begin
                    state_nx = WR_WAIT;
                end else if (rd_acc) begin
                    state_nx = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (expire) begin
                    state_nx = RD_RESP;
                end
            end
            RD_RESP: begin
                if (rready) begin
                    state_nx = IDLE;
                end
            end
            WR_WAIT: begin
                if (expire) begin
                    state_nx = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // State, request latches, counter and response registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
            bresp   <= RESP_OKAY;
        end else begin
            state <= state_nx;

            if (wr_acc) begin
                addr_q  <= awaddr;
                wdata_q <= wdata;
                wstrb_q <= wstrb;
                cnt     <= delay;
            end else if (rd_acc) begin
                addr_q <= araddr;
                cnt    <= delay;
            end else if (waiting) begin
                cnt <= expire ? '0 : cnt - CNT_W'(1);
            end

            // Response payload is loaded only on expiry and then held
            // untouched for as long as the initiator stalls.
            if ((state == RD_WAIT) && expire) begin
                rdata <= in_range ? mem[idx] : 32'h0;
                rresp <= in_range ? RESP_OKAY : RESP_SLVERR;
            end

            if ((state == WR_WAIT) && expire) begin
                bresp <= in_range ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // ---------------------------------------------------------------
    // Array write: commits on the edge that raises bvalid. Reset forces
    // the state to IDLE, so a write dropped by reset never commits.
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if ((state == WR_WAIT) && expire && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_q[i]) begin
                    mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_25020047_sram.sv
module tb_ysyx_25020047_sram;
    import ysyx_25020047_pkg::*;

    // ------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------
    logic clk;
    logic rst;
    logic rst4;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------
    // Shared request bus; sel steers valids/readies to one instance
    // (0: LATENCY=1 instance, 1: LATENCY=4 instance)
    // ------------------------------------------------------------
    logic        sel;
    logic [31:0] araddr, awaddr, wdata;
    logic [3:0]  wstrb;
    logic        arvalid, rready, awvalid, wvalid, bready;

    logic        d1_arready, d1_rvalid, d1_awready, d1_wready, d1_bvalid;
    logic [31:0] d1_rdata;
    logic [1:0]  d1_rresp, d1_bresp;
    state_t      d1_state;

    logic        d4_arready, d4_rvalid, d4_awready, d4_wready, d4_bvalid;
    logic [31:0] d4_rdata;
    logic [1:0]  d4_rresp, d4_bresp;
    state_t      d4_state;

    logic        m_arready, m_rvalid, m_awready, m_wready, m_bvalid;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp, m_bresp;
    state_t      m_state;

    assign m_arready = sel ? d4_arready : d1_arready;
    assign m_rvalid  = sel ? d4_rvalid  : d1_rvalid;
    assign m_awready = sel ? d4_awready : d1_awready;
    assign m_wready  = sel ? d4_wready  : d1_wready;
    assign m_bvalid  = sel ? d4_bvalid  : d1_bvalid;
    assign m_rdata   = sel ? d4_rdata   : d1_rdata;
    assign m_rresp   = sel ? d4_rresp   : d1_rresp;
    assign m_bresp   = sel ? d4_bresp   : d1_bresp;
    assign m_state   = sel ? d4_state   : d1_state;

    ysyx_25020047_sram #(.LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid & ~sel), .arready(d1_arready),
        .rdata(d1_rdata), .rresp(d1_rresp), .rvalid(d1_rvalid), .rready(rready & ~sel),
        .awaddr(awaddr), .awvalid(awvalid & ~sel), .awready(d1_awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid & ~sel), .wready(d1_wready),
        .bresp(d1_bresp), .bvalid(d1_bvalid), .bready(bready & ~sel),
        .dbg_state(d1_state)
    );

    ysyx_25020047_sram #(.LATENCY(4)) dut4 (
        .clk(clk), .rst(rst4),
        .araddr(araddr), .arvalid(arvalid & sel), .arready(d4_arready),
        .rdata(d4_rdata), .rresp(d4_rresp), .rvalid(d4_rvalid), .rready(rready & sel),
        .awaddr(awaddr), .awvalid(awvalid & sel), .awready(d4_awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid & sel), .wready(d4_wready),
        .bresp(d4_bresp), .bvalid(d4_bvalid), .bready(bready & sel),
        .dbg_state(d4_state)
    );

    // ------------------------------------------------------------
    // Scoreboard bookkeeping
    // ------------------------------------------------------------
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_lat(input string tag, input int lat, input int lo, input int hi);
        checks++;
        assert (lat >= lo && lat <= hi) else begin
            failures++;
            $error("FAIL %s latency observed=%0d expected=%0d..%0d", tag, lat, lo, hi);
        end
    endtask

    // ------------------------------------------------------------
    // Driver tasks (start and end 1 time unit after a rising edge)
    // ------------------------------------------------------------
    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                      input logic [1:0] exp_resp, input int lo, input int hi, input string tag);
        int n;
        int lat;
        awaddr  = addr;
        wdata   = data;
        wstrb   = strb;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        bready  = 1'b0;
        n = 0;
        @(negedge clk);
        while (!(m_awready && m_wready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_accept"}, 32'(m_awready && m_wready), 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        lat = 0;
        while (!m_bvalid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk_lat({tag, "_lat"}, lat, lo, hi);
        chk({tag, "_bresp"}, 32'(m_bresp), 32'(exp_resp));
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp,
                      input int lo, input int hi, input int hold, input string tag);
        int n;
        int lat;
        araddr  = addr;
        arvalid = 1'b1;
        rready  = 1'b0;
        n = 0;
        @(negedge clk);
        while (!m_arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_accept"}, 32'(m_arready), 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        lat = 0;
        while (!m_rvalid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk_lat({tag, "_lat"}, lat, lo, hi);
        chk({tag, "_rdata"}, m_rdata, exp_data);
        chk({tag, "_rresp"}, 32'(m_rresp), 32'(exp_resp));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_rvalid"}, 32'(m_rvalid), 32'd1);
            chk({tag, "_hold_rdata"}, m_rdata, exp_data);
            chk({tag, "_hold_arready"}, 32'(m_arready), 32'd0);
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    // ------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------
    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        int          idx;
        bit          oor;

        sel = 1'b0; rst = 1'b0; rst4 = 1'b0;
        araddr = '0; awaddr = '0; wdata = '0; wstrb = '0;
        arvalid = 1'b0; rready = 1'b0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rvalid",  32'(d1_rvalid), 32'd0);
        chk("rst_bvalid",  32'(d1_bvalid), 32'd0);
        chk("rst_rdata",   d1_rdata, 32'd0);
        chk("rst_rresp",   32'(d1_rresp), 32'd0);
        chk("rst_bresp",   32'(d1_bresp), 32'd0);
        chk("rst_state",   32'(d1_state), 32'(IDLE));
        chk("rst_arready", 32'(d1_arready), 32'd1);
        chk("rst_awready", 32'(d1_awready), 32'd0);
        rst = 1'b1;
        rst4 = 1'b1;
        @(posedge clk); #1;

`ifdef YSYX_25020047_SRAM_RAND_DELAY_EN
        for (int i = 0; i < 16; i++) begin
            model[i] = $urandom;
            wr(32'h8000_0000 + 32'(i * 4), model[i], 4'hF, RESP_OKAY, 1, 16, "init_wr");
        end
        for (int n = 0; n < 200; n++) begin
            idx = $urandom_range(0, 15);
            oor = ($urandom_range(0, 9) == 0);
            a = (oor ? 32'h9000_0000 : 32'h8000_0000) + 32'(idx * 4);
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                if (!oor) begin
                    for (int b = 0; b < 4; b++) begin
                        if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
                    end
                end
                wr(a, d, s, oor ? RESP_SLVERR : RESP_OKAY, 1, 16, "rnd_wr");
            end else begin
                exp_q.push_back(oor ? 32'h0 : model[idx]);
                rd(a, exp_q.pop_front(), oor ? RESP_SLVERR : RESP_OKAY, 1, 16, 0, "rnd_rd");
            end
        end
`else
        // Basic read/write
        wr(32'h8000_0010, 32'hDEADBEEF, 4'hF, RESP_OKAY, 1, 1, "basic_wr");
        rd(32'h8000_0010, 32'hDEADBEEF, RESP_OKAY, 1, 1, 0, "basic_rd");

        // Byte strobe
        wr(32'h8000_0010, 32'h11223344, 4'b0101, RESP_OKAY, 1, 1, "strb_wr");
        rd(32'h8000_0010, 32'hDE22BE44, RESP_OKAY, 1, 1, 0, "strb_rd");
        rd(32'h8000_0013, 32'hDE22BE44, RESP_OKAY, 1, 1, 0, "unalign_rd");

        // Out of range, both ends of the window
        rd(32'h7FFF_FFFC, 32'h0, RESP_SLVERR, 1, 1, 0, "oor_low_rd");
        wr(32'h8000_0000, 32'hCAFEF00D, 4'hF, RESP_OKAY, 1, 1, "w0_wr");
        wr(32'h8000_4000, 32'h0BADBAD0, 4'hF, RESP_SLVERR, 1, 1, "oor_high_wr");
        rd(32'h8000_0000, 32'hCAFEF00D, RESP_OKAY, 1, 1, 0, "w0_unchanged_rd");
        wr(32'h8000_3FFC, 32'hA5A5_0001, 4'hF, RESP_OKAY, 1, 1, "last_wr");
        rd(32'h8000_3FFC, 32'hA5A5_0001, RESP_OKAY, 1, 1, 0, "last_rd");

        // Backpressure: rready low for 5 cycles
        rd(32'h8000_0010, 32'hDE22BE44, RESP_OKAY, 1, 1, 5, "bp_rd");

        // Priority: read and write raised together in IDLE
        araddr = 32'h8000_0020; awaddr = 32'h8000_0020;
        wdata = 32'h0102_0304; wstrb = 4'hF;
        arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        chk("prio_awready", 32'(d1_awready), 32'd1);
        chk("prio_wready",  32'(d1_wready), 32'd1);
        chk("prio_arready_blocked", 32'(d1_arready), 32'd0);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        chk("prio_state_wrwait", 32'(d1_state), 32'(WR_WAIT));
        chk("prio_arready_wrwait", 32'(d1_arready), 32'd0);
        @(posedge clk); #1;
        chk("prio_bvalid", 32'(d1_bvalid), 32'd1);
        chk("prio_arready_wrresp", 32'(d1_arready), 32'd0);
        @(posedge clk); #1;
        chk("prio_state_idle", 32'(d1_state), 32'(IDLE));
        chk("prio_arready_after_b", 32'(d1_arready), 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        chk("prio_state_rdwait", 32'(d1_state), 32'(RD_WAIT));
        @(posedge clk); #1;
        chk("prio_rvalid", 32'(d1_rvalid), 32'd1);
        chk("prio_rdata", d1_rdata, 32'h0102_0304);
        @(posedge clk); #1;
        rready = 1'b0; bready = 1'b0;
        chk("prio_state_end", 32'(d1_state), 32'(IDLE));

        // Asynchronous reset while a read response is pending
        araddr = 32'h8000_0010; arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(posedge clk); #1;
        chk("rstrd_rvalid_before", 32'(d1_rvalid), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("rstrd_rvalid_async", 32'(d1_rvalid), 32'd0);
        chk("rstrd_state", 32'(d1_state), 32'(IDLE));
        #2 rst = 1'b1;
        @(posedge clk); #1;

        // Reset mid-write on the LATENCY=4 instance
        sel = 1'b1;
        @(posedge clk); #1;
        wr(32'h8000_0040, 32'h55AA55AA, 4'hF, RESP_OKAY, 4, 4, "d4_wr");
        awaddr = 32'h8000_0040; wdata = 32'h1234_5678; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        chk("d4_rstwr_accept", 32'(d4_awready), 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        chk("d4_rstwr_state", 32'(d4_state), 32'(WR_WAIT));
        @(posedge clk); #1;
        #2 rst4 = 1'b0;
        #1;
        chk("d4_rstwr_bvalid", 32'(d4_bvalid), 32'd0);
        chk("d4_rstwr_idle", 32'(d4_state), 32'(IDLE));
        repeat (2) @(posedge clk);
        #1 rst4 = 1'b1;
        @(posedge clk); #1;
        rd(32'h8000_0040, 32'h55AA55AA, RESP_OKAY, 4, 4, 0, "d4_old_rd");
        sel = 1'b0;
`endif

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_25020047_sram.md
# ysyx_25020047_sram

Memory-side responder for the NPC's instruction-fetch and load/store ports. It is the slave end of the valid/ready memory handshake that IFU and LSU initiate, with an AXI4-Lite-style split of read address/data and write address/data/response channels. It holds a word-addressed backing array and answers each request after a programmable delay, which exercises the initiators' wait-state handling. One instance serves one initiator; IFU and LSU each get their own instance, or share one through a later arbiter.

## Interface
- `BASE`, 32'h8000_0000: first byte address mapped.
- `DEPTH`, 4096: number of 32-bit words; power of two.
- `LATENCY`, 1: fixed response delay in cycles (≥1), used when random delay is compiled out.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `araddr` in 32: read address.
- `arvalid` in 1, `arready` out 1: read-address handshake.
- `rdata` out 32: read data word.
- `rresp` out 2: 00 OKAY, 10 SLVERR.
- `rvalid` out 1, `rready` in 1: read-data handshake.
- `awaddr` in 32, `wdata` in 32, `wstrb` in 4: write address, data and byte mask.
- `awvalid`/`wvalid` in 1, `awready`/`wready` out 1: write handshakes.
- `bresp` out 2, `bvalid` out 1, `bready` in 1: write response.

## Operation
- FSM states: IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP. One transaction in flight.
- `arready` = IDLE && !(awvalid && wvalid). Writes take priority when a read and a write are both pending in IDLE.
- `awready` = `wready` = IDLE && awvalid && wvalid. AW and W are always accepted in the same cycle and never separately.
- Read accept: latch the address and load the delay counter, then go to RD_WAIT. When the counter expires, drive `rdata`/`rresp`, assert `rvalid` and go to RD_RESP. Stay in RD_RESP until `rready`, then return to IDLE.
- Write accept: latch awaddr, wdata and wstrb, then go to WR_WAIT. On expiry, commit the byte lanes where `wstrb[i]`=1, assert `bvalid` and go to WR_RESP. Stay there until `bready`, then return to IDLE.
- Address decode:
  - Index = addr[log2(DEPTH)+1:2].
  - An address is in range iff BASE ≤ addr < BASE+4·DEPTH.
  - Out of range: `rresp`/`bresp` = 10, `rdata` = 0, no array write.
  - addr[1:0] is ignored and the access is word-aligned.
- Response outputs hold stable while valid && !ready.

## Timing
- Handshake completes at edge E0. With delay D, `rvalid`/`bvalid` rises after edge E0+D, so D=1 gives valid in the cycle immediately after acceptance.
- Ready asserted in the same cycle as valid means the transfer completes at that edge. The next request can be accepted in the cycle after the response handshake.
- The array write commits at the same edge that raises `bvalid`. A read issued after a completed write returns the new data.
- Reset values: `rvalid`=0, `bvalid`=0, `rdata`=0, `rresp`=00, `bresp`=00, state IDLE, counter 0. The array is not cleared.
- Reset mid-transaction drops the transaction, the valids fall asynchronously, and any pending write is not committed.
- `arready`/`awready`/`wready` are combinational from the state and the valids, with no path from `rready`/`bready`.

## Configuration
- `YSYX_25020047_SRAM_RAND_DELAY_EN`:
  - Defined: D = 1 + lfsr[3:0], giving 1..16 cycles. The LFSR is 8 bits with polynomial x^8+x^6+x^5+x^4+1, seeds 8'hA5 on reset and advances every cycle. D is sampled at the accepting edge.
  - Undefined: D = LATENCY for every transaction and no LFSR is built.

## Structure
- Package `ysyx_25020047_pkg` holds:
  - response codes RESP_OKAY and RESP_SLVERR;
  - the state enum;
  - the LFSR seed and tap constants.
- Sub-module `ysyx_25020047_lfsr8` (clk, rst, out[7:0]) is instantiated only under the macro.

## Test plan
- **Basic read/write:** LATENCY=1. Write 0x8000_0010 ← 32'hDEADBEEF with wstrb=4'hF, `bready`=1, then read the same address. Required: `bvalid` one cycle after AW/W acceptance, `rdata`=32'hDEADBEEF with `rresp`=00, `rvalid` one cycle after AR acceptance.
- **Byte strobe:** over the existing word, write 32'h11223344 with wstrb=4'b0101. A read returns 32'hDE22BE44.
- **Out of range and backpressure:**
  - Read 0x7FFF_FFFC returns `rresp`=10 and `rdata`=0.
  - Write 0x8000_4000 (DEPTH=4096) returns `bresp`=10 and the array is unchanged.
  - Hold `rready`=0 for 5 cycles: `rvalid` and `rdata` stay stable and `arready`=0 throughout.
- **Priority:** arvalid, awvalid and wvalid all rise in the same IDLE cycle. The write is accepted first, then the read is accepted in the cycle after the `bvalid`/`bready` handshake.
- **Reset mid-write:** assert `rst`=0 during WR_WAIT with LATENCY=4. The valids drop immediately, and after release a read of that address shows the old data.
- **Random delay (macro defined):** run 200 random reads and writes against a scoreboard. Every delay lies in 1..16 and all data matches.
